// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating history counters.
// Combinational IF-stage lookup, EX-stage update, mispredict detection and optional statistics.
module branch_predictor #(
  parameter int ENTRY_NUM = 64,
  parameter int CNT_W     = 2,
  parameter bit STAT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        UpdateE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BrNPC,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT   = CNT_W'(1 << (CNT_W - 1));

  logic [ENTRY_NUM-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRY_NUM];
  logic [31:0]          target_q [ENTRY_NUM];
  logic [CNT_W-1:0]     cnt_q    [ENTRY_NUM];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic [CNT_W-1:0] cnt_e, cnt_d;

  // The byte-offset bits of both PCs carry no information for a word-aligned ISA.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign PredTakenF  = hit_f && cnt_q[idx_f][CNT_W-1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;

  assign MispredictE = UpdateE && ((PredTakenE != BranchE) ||
                                   (PredTakenE && BranchE && (PredTargetE != BrNPC)));
  assign RecoverPCE  = (UpdateE && BranchE) ? BrNPC : PCE + 32'd4;

  always_comb begin
    cnt_e = cnt_q[idx_e];
    cnt_d = cnt_e;
    if (BranchE) begin
      if (cnt_e != CNT_MAX) cnt_d = cnt_e + CNT_W'(1);
    end else begin
      if (cnt_e != '0) cnt_d = cnt_e - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) cnt_q[i] <= CNT_INIT;
    end else if (UpdateE) begin
      if (hit_e) begin
        cnt_q[idx_e] <= cnt_d;
      end else if (BranchE) begin
        valid_q[idx_e] <= 1'b1;
        cnt_q[idx_e]   <= CNT_WT;
      end
    end
  end

  // NOTE: tags and targets are deliberately left out of reset; a cleared valid bit
  // masks whatever they hold, so resetting this wide storage buys nothing.
  always_ff @(posedge clk) begin
    if (UpdateE && BranchE) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= BrNPC;
    end
  end

  if (STAT_EN) begin : g_stat
    logic [31:0] branch_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        branch_cnt_q  <= '0;
        mispred_cnt_q <= '0;
      end else begin
        if (UpdateE)     branch_cnt_q  <= branch_cnt_q + 32'd1;
        if (MispredictE) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;
  end else begin : g_no_stat
    assign BranchCnt  = '0;
    assign MispredCnt = '0;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a 2-bit-counter instance with statistics and a
// 1-bit-counter instance without, both driven by the same branch stream.
module tb_branch_predictor;

  typedef struct {
    logic        upd;
    logic [31:0] pc;
    logic        br;
    logic [31:0] npc;
    logic        ptk;
    logic [31:0] ptg;
    logic        misp;
    logic [31:0] rec;
    logic [31:0] lpc;
    logic        t2;
    logic [31:0] g2;
    logic        t1;
    logic [31:0] g1;
  } row_t;

  typedef struct { logic misp; logic [31:0] rec; } upd_exp_t;
  typedef struct { logic t2; logic [31:0] g2; logic t1; logic [31:0] g1; } look_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, BrNPC, PredTargetE;
  logic        UpdateE, BranchE, PredTakenE;

  logic        pt2, misp2, pt1, misp1;
  logic [31:0] ptg2, rec2, bc2, mc2, ptg1, rec1, bc1, mc1;

  upd_exp_t  upd_q[$];
  look_exp_t look_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_br = '0;
  logic [31:0] exp_mp = '0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRY_NUM(64), .CNT_W(2), .STAT_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(pt2), .PredTargetF(ptg2),
    .UpdateE(UpdateE), .PCE(PCE), .BranchE(BranchE), .BrNPC(BrNPC),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(misp2), .RecoverPCE(rec2), .BranchCnt(bc2), .MispredCnt(mc2)
  );

  branch_predictor #(.ENTRY_NUM(64), .CNT_W(1), .STAT_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(pt1), .PredTargetF(ptg1),
    .UpdateE(UpdateE), .PCE(PCE), .BranchE(BranchE), .BrNPC(BrNPC),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(misp1), .RecoverPCE(rec1), .BranchCnt(bc1), .MispredCnt(mc1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    UpdateE = 1'b0;
  endtask

  task automatic drive_update(input row_t r);
    UpdateE     = r.upd;
    PCE         = r.pc;
    BranchE     = r.br;
    BrNPC       = r.npc;
    PredTakenE  = r.ptk;
    PredTargetE = r.ptg;
    upd_q.push_back('{r.misp, r.rec});
    if (r.upd) begin
      exp_br++;
      if (r.misp) exp_mp++;
    end
  endtask

  task automatic drive_lookup(input logic [31:0] pc, input logic t2, input logic [31:0] g2,
                              input logic t1, input logic [31:0] g1);
    PCF = pc;
    look_q.push_back('{t2, g2, t1, g1});
  endtask

  task automatic test_reset;
    row_t r;
    upd_exp_t u;
    look_exp_t l;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    r = '{1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44,
          32'h100, 1'b0, 32'h104, 1'b0, 32'h104};
    drive_update(r);
    drive_lookup(r.lpc, r.t2, r.g2, r.t1, r.g1);
    #1;
    u = upd_q.pop_front();
    checks++;
    if ({misp2, rec2, misp1, rec1} !== {u.misp, u.rec, u.misp, u.rec}) begin
      errors++;
      $display("FAIL reset_idle_recover: got misp=%0b/%0b rec=%h/%h, expected misp=%0b rec=%h",
               misp2, misp1, rec2, rec1, u.misp, u.rec);
    end
    l = look_q.pop_front();
    checks++;
    if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
      errors++;
      $display("FAIL reset_lookup: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
               pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
    end
    checks++;
    if ({bc2, mc2, bc1, mc1} !== {exp_br, exp_mp, 64'h0}) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d (%0d/%0d), expected %0d/%0d (0/0)",
               bc2, mc2, bc1, mc1, exp_br, exp_mp);
    end
  endtask

  task automatic test_alloc;
    row_t rows[1];
    upd_exp_t u;
    look_exp_t l;
    rows = '{'{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80,
               32'h100, 1'b1, 32'h80, 1'b1, 32'h80}};
    foreach (rows[i]) begin
      drive_update(rows[i]);
      #1;
      u = upd_q.pop_front();
      checks++;
      if ({misp2, rec2, misp1, rec1} !== {u.misp, u.rec, u.misp, u.rec}) begin
        errors++;
        $display("FAIL alloc_mispredict[%0d]: got misp=%0b/%0b rec=%h/%h, expected misp=%0b rec=%h",
                 i, misp2, misp1, rec2, rec1, u.misp, u.rec);
      end
      tick;
      drive_lookup(rows[i].lpc, rows[i].t2, rows[i].g2, rows[i].t1, rows[i].g1);
      #1;
      l = look_q.pop_front();
      checks++;
      if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
        errors++;
        $display("FAIL alloc_lookup[%0d]: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
                 i, pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
      end
    end
    checks++;
    if ({bc2, mc2, bc1, mc1} !== {exp_br, exp_mp, 64'h0}) begin
      errors++;
      $display("FAIL alloc_stats: got %0d/%0d (%0d/%0d), expected %0d/%0d (0/0)",
               bc2, mc2, bc1, mc1, exp_br, exp_mp);
    end
  endtask

  // Counters walk up to saturation, down through the threshold, and must hold at zero.
  task automatic test_saturate;
    row_t rows[9];
    upd_exp_t u;
    look_exp_t l;
    rows = '{
      '{1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80,  1'b0, 32'h80,  32'h100, 1'b1, 32'h80,  1'b1, 32'h80},
      '{1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80,  1'b0, 32'h80,  32'h100, 1'b1, 32'h80,  1'b1, 32'h80},
      '{1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80,  1'b0, 32'h80,  32'h100, 1'b1, 32'h80,  1'b1, 32'h80},
      '{1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80,  1'b1, 32'h104, 32'h100, 1'b1, 32'h80,  1'b0, 32'h104},
      '{1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80,  1'b1, 32'h104, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104},
      '{1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104},
      '{1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104},
      '{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80,  32'h100, 1'b0, 32'h104, 1'b1, 32'h80},
      '{1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104}
    };
    foreach (rows[i]) begin
      drive_update(rows[i]);
      #1;
      u = upd_q.pop_front();
      checks++;
      if ({misp2, rec2, misp1, rec1} !== {u.misp, u.rec, u.misp, u.rec}) begin
        errors++;
        $display("FAIL saturate_mispredict[%0d]: got misp=%0b/%0b rec=%h/%h, expected misp=%0b rec=%h",
                 i, misp2, misp1, rec2, rec1, u.misp, u.rec);
      end
      tick;
      drive_lookup(rows[i].lpc, rows[i].t2, rows[i].g2, rows[i].t1, rows[i].g1);
      #1;
      l = look_q.pop_front();
      checks++;
      if ({pt2, ptg2} !== {l.t2, l.g2}) begin
        errors++;
        $display("FAIL saturate_lookup_cnt2[%0d]: got %0b/%h, expected %0b/%h",
                 i, pt2, ptg2, l.t2, l.g2);
      end
      checks++;
      if ({pt1, ptg1} !== {l.t1, l.g1}) begin
        errors++;
        $display("FAIL saturate_lookup_cnt1[%0d]: got %0b/%h, expected %0b/%h",
                 i, pt1, ptg1, l.t1, l.g1);
      end
    end
    checks++;
    if ({bc2, mc2, bc1, mc1} !== {exp_br, exp_mp, 64'h0}) begin
      errors++;
      $display("FAIL saturate_stats: got %0d/%0d (%0d/%0d), expected %0d/%0d (0/0)",
               bc2, mc2, bc1, mc1, exp_br, exp_mp);
    end
  endtask

  // 0x100, 0x200 and 0x300 share index 0 with different tags.
  task automatic test_alias;
    row_t rows[3];
    upd_exp_t u;
    look_exp_t l;
    rows = '{
      '{1'b1, 32'h200, 1'b1, 32'h240, 1'b0, 32'h204, 1'b1, 32'h240, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104},
      '{1'b0, 32'h300, 1'b1, 32'h340, 1'b0, 32'h304, 1'b0, 32'h304, 32'h200, 1'b1, 32'h240, 1'b1, 32'h240},
      '{1'b1, 32'h300, 1'b0, 32'h340, 1'b0, 32'h304, 1'b0, 32'h304, 32'h200, 1'b1, 32'h240, 1'b1, 32'h240}
    };
    foreach (rows[i]) begin
      drive_update(rows[i]);
      #1;
      u = upd_q.pop_front();
      checks++;
      if ({misp2, rec2, misp1, rec1} !== {u.misp, u.rec, u.misp, u.rec}) begin
        errors++;
        $display("FAIL alias_mispredict[%0d]: got misp=%0b/%0b rec=%h/%h, expected misp=%0b rec=%h",
                 i, misp2, misp1, rec2, rec1, u.misp, u.rec);
      end
      tick;
      drive_lookup(rows[i].lpc, rows[i].t2, rows[i].g2, rows[i].t1, rows[i].g1);
      #1;
      l = look_q.pop_front();
      checks++;
      if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
        errors++;
        $display("FAIL alias_lookup[%0d]: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
                 i, pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
      end
    end
    drive_lookup(32'h200, 1'b1, 32'h240, 1'b1, 32'h240);
    #1;
    l = look_q.pop_front();
    checks++;
    if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
      errors++;
      $display("FAIL alias_new_entry: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
               pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
    end
    checks++;
    if ({bc2, mc2} !== {exp_br, exp_mp}) begin
      errors++;
      $display("FAIL alias_stats: got %0d/%0d, expected %0d/%0d", bc2, mc2, exp_br, exp_mp);
    end
  endtask

  task automatic test_same_cycle;
    row_t r;
    upd_exp_t u;
    look_exp_t l;
    r = '{1'b1, 32'h104, 1'b1, 32'h400, 1'b0, 32'h108, 1'b1, 32'h400,
          32'h104, 1'b0, 32'h108, 1'b0, 32'h108};
    drive_update(r);
    drive_lookup(r.lpc, r.t2, r.g2, r.t1, r.g1);
    #1;
    u = upd_q.pop_front();
    checks++;
    if ({misp2, rec2, misp1, rec1} !== {u.misp, u.rec, u.misp, u.rec}) begin
      errors++;
      $display("FAIL same_cycle_mispredict: got misp=%0b/%0b rec=%h/%h, expected misp=%0b rec=%h",
               misp2, misp1, rec2, rec1, u.misp, u.rec);
    end
    l = look_q.pop_front();
    checks++;
    if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
      errors++;
      $display("FAIL same_cycle_no_bypass: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
               pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
    end
    tick;
    drive_lookup(32'h104, 1'b1, 32'h400, 1'b1, 32'h400);
    #1;
    l = look_q.pop_front();
    checks++;
    if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
      errors++;
      $display("FAIL same_cycle_next: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
               pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
    end
    r = '{1'b1, 32'h104, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90,
          32'h104, 1'b1, 32'h90, 1'b1, 32'h90};
    drive_update(r);
    #1;
    u = upd_q.pop_front();
    checks++;
    if ({misp2, rec2, misp1, rec1} !== {u.misp, u.rec, u.misp, u.rec}) begin
      errors++;
      $display("FAIL target_mismatch: got misp=%0b/%0b rec=%h/%h, expected misp=%0b rec=%h",
               misp2, misp1, rec2, rec1, u.misp, u.rec);
    end
    tick;
    drive_lookup(r.lpc, r.t2, r.g2, r.t1, r.g1);
    #1;
    l = look_q.pop_front();
    checks++;
    if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
      errors++;
      $display("FAIL target_rewrite: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
               pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
    end
    checks++;
    if ({bc2, mc2} !== {exp_br, exp_mp}) begin
      errors++;
      $display("FAIL same_cycle_stats: got %0d/%0d, expected %0d/%0d", bc2, mc2, exp_br, exp_mp);
    end
  endtask

  // Reset is raised between clock edges; its effect must be visible before the next edge.
  task automatic test_mid_reset;
    look_exp_t l;
    drive_lookup(32'h200, 1'b1, 32'h240, 1'b1, 32'h240);
    #1;
    l = look_q.pop_front();
    checks++;
    if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
      errors++;
      $display("FAIL pre_reset_hit: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
               pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
    end
    rst    = 1'b1;
    exp_br = '0;
    exp_mp = '0;
    drive_lookup(32'h200, 1'b0, 32'h204, 1'b0, 32'h204);
    #1;
    l = look_q.pop_front();
    checks++;
    if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
      errors++;
      $display("FAIL async_reset_lookup: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
               pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
    end
    checks++;
    if ({bc2, mc2} !== {exp_br, exp_mp}) begin
      errors++;
      $display("FAIL async_reset_stats: got %0d/%0d, expected %0d/%0d", bc2, mc2, exp_br, exp_mp);
    end
    @(negedge clk);
    rst = 1'b0;
    tick;
    drive_lookup(32'h104, 1'b0, 32'h108, 1'b0, 32'h108);
    #1;
    l = look_q.pop_front();
    checks++;
    if ({pt2, ptg2, pt1, ptg1} !== {l.t2, l.g2, l.t1, l.g1}) begin
      errors++;
      $display("FAIL post_reset_lookup: got %0b/%h %0b/%h, expected %0b/%h %0b/%h",
               pt2, ptg2, pt1, ptg1, l.t2, l.g2, l.t1, l.g1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    PCF         = '0;
    PCE         = '0;
    BrNPC       = '0;
    PredTargetE = '0;
    UpdateE     = 1'b0;
    BranchE     = 1'b0;
    PredTakenE  = 1'b0;
    test_reset();
    test_alloc();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
